tpm_response_tx: RTL and testbench

TPM_RESPONSE_TX -- requirements
Module: tpm_response_tx

---
 rtl/tpm_response_tx_pkg.sv | 48 ++++
 rtl/tpm_response_tx.sv | 169 ++++++++++++++++
 tb/tb_tpm_response_tx.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/tpm_response_tx_pkg.sv
// Shared TPM constants: structure tags, response codes, header geometry,
// and the response-transmitter FSM state encoding.
// Latency: n/a (constants and pure functions only). Backpressure: n/a.
package tpm_response_tx_pkg;

  localparam logic [15:0] TPM_ST_NO_SESSIONS = 16'h8001;
  localparam logic [15:0] TPM_ST_SESSIONS    = 16'h8002;
  localparam logic [31:0] TPM_RC_SUCCESS     = 32'h0000_0000;
  localparam logic [31:0] TPM_RC_FAILURE     = 32'h0000_0101;

  // Response header: tag(2) + size(4) + rc(4) bytes.
  localparam int unsigned TPM_HDR_LEN  = 10;
  localparam logic [3:0]  HDR_LAST_IDX = 4'(TPM_HDR_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_FETCH = 3'd2,
    ST_SEND  = 3'd3,
    ST_DONE  = 3'd4
  } rsp_state_e;

  typedef struct packed {
    logic [15:0] tag;
    logic [31:0] size;
    logic [31:0] rc;
  } rsp_hdr_t;

  // Big-endian serialisation of the header, byte 0 first.
  function automatic logic [7:0] hdr_byte(input rsp_hdr_t h, input logic [3:0] i);
    logic [7:0] b;
    case (i)
      4'd0:    b = h.tag[15:8];
      4'd1:    b = h.tag[7:0];
      4'd2:    b = h.size[31:24];
      4'd3:    b = h.size[23:16];
      4'd4:    b = h.size[15:8];
      4'd5:    b = h.size[7:0];
      4'd6:    b = h.rc[31:24];
      4'd7:    b = h.rc[23:16];
      4'd8:    b = h.rc[15:8];
      4'd9:    b = h.rc[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/tpm_response_tx.sv
// TPM response transmitter: serialises a 10-byte big-endian header followed
// by parameter bytes read from an external byte buffer.
// Latency: first tx_valid 1 cycle after rsp_start; header 1 B/cycle, params 1 B/2 cycles.
// Backpressure: tx_valid/tx_ready; the presented byte is held stable until accepted.
//
// Ports:
//   clock, reset_n                 - single clock, synchronous active-low reset
//   rsp_start, tpm_rc, rsp_tag,
//   param_len                      - response request, sampled only in IDLE
//   param_rd_en, param_addr,
//   param_data                     - parameter buffer read port (1-cycle read latency)
//   tx_data, tx_valid, tx_ready,
//   tx_last                        - byte stream towards the host interface
//   busy, done                     - status: not idle / one-cycle completion pulse
module tpm_response_tx
  import tpm_response_tx_pkg::*;
#(
  parameter int unsigned MAX_PARAM = 1014
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rsp_start,
  input  logic [31:0] tpm_rc,
  input  logic [15:0] rsp_tag,
  input  logic [15:0] param_len,
  output logic        param_rd_en,
  output logic [9:0]  param_addr,
  input  logic [7:0]  param_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic        busy,
  output logic        done
);

  rsp_state_e  state_q, state_d;
  rsp_hdr_t    hdr_q, hdr_d;
  logic [15:0] plen_q, plen_d;
  logic [3:0]  hcnt_q, hcnt_d;
  logic [15:0] idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  // Set once a parameter byte has been stalled; from then on the byte comes
  // from data_q rather than the buffer output.
  logic        hold_q, hold_d;
  logic        param_last;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      hdr_q   <= '0;
      plen_q  <= '0;
      hcnt_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      plen_q  <= plen_d;
      hcnt_q  <= hcnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      hold_q  <= hold_d;
    end
  end

  assign param_last = (idx_q == (plen_q - 16'd1));

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    plen_d      = plen_q;
    hcnt_d      = hcnt_q;
    idx_d       = idx_q;
    data_d      = data_q;
    hold_d      = hold_q;
    param_rd_en = 1'b0;
    param_addr  = 10'd0;
    tx_data     = 8'h00;
    tx_valid    = 1'b0;
    tx_last     = 1'b0;
    busy        = (state_q != ST_IDLE);
    done        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rsp_start) begin
          if (tpm_rc != TPM_RC_SUCCESS) begin
            // Error responses never carry parameters.
            hdr_d.tag  = TPM_ST_NO_SESSIONS;
            hdr_d.rc   = tpm_rc;
            hdr_d.size = 32'(TPM_HDR_LEN);
            plen_d     = 16'd0;
          end else if ({16'h0000, param_len} > 32'(MAX_PARAM)) begin
            // Oversized parameter block turns into a failure response.
            hdr_d.tag  = TPM_ST_NO_SESSIONS;
            hdr_d.rc   = TPM_RC_FAILURE;
            hdr_d.size = 32'(TPM_HDR_LEN);
            plen_d     = 16'd0;
          end else begin
            hdr_d.tag  = rsp_tag;
            hdr_d.rc   = tpm_rc;
            hdr_d.size = 32'(TPM_HDR_LEN) + {16'h0000, param_len};
            plen_d     = param_len;
          end
          hcnt_d  = 4'd0;
          idx_d   = 16'd0;
          hold_d  = 1'b0;
          state_d = ST_HDR;
        end
      end

      ST_HDR: begin
        tx_valid = 1'b1;
        tx_data  = hdr_byte(hdr_q, hcnt_q);
        tx_last  = (hcnt_q == HDR_LAST_IDX) && (plen_q == 16'd0);
        if (tx_ready) begin
          if (hcnt_q == HDR_LAST_IDX) begin
            hcnt_d  = 4'd0;
            idx_d   = 16'd0;
            state_d = (plen_q == 16'd0) ? ST_DONE : ST_FETCH;
          end else begin
            hcnt_d = hcnt_q + 4'd1;
          end
        end
      end

      ST_FETCH: begin
        param_rd_en = 1'b1;
        param_addr  = idx_q[9:0];
        hold_d      = 1'b0;
        state_d     = ST_SEND;
      end

      ST_SEND: begin
        // Buffer output is valid in the first SEND cycle; it is captured then
        // so the byte stays stable however long the host stalls.
        tx_valid = 1'b1;
        tx_data  = hold_q ? data_q : param_data;
        tx_last  = param_last;
        if (tx_ready) begin
          hold_d = 1'b0;
          if (param_last) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 16'd1;
            state_d = ST_FETCH;
          end
        end else begin
          hold_d = 1'b1;
          if (!hold_q) begin
            data_d = param_data;
          end
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_tpm_response_tx.sv
module tb_tpm_response_tx;

  localparam int MAX_P = 1014;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        rsp_start;
  logic [31:0] tpm_rc;
  logic [15:0] rsp_tag;
  logic [15:0] param_len;
  logic        param_rd_en;
  logic [9:0]  param_addr;
  logic [7:0]  param_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_last;
  logic        busy;
  logic        done;

  logic [7:0]  mem [0:1023];

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] rc;
    logic [15:0] tag;
    logic [15:0] plen;
    int          stall;
    logic [15:0] e_tag;
    logic [31:0] e_size;
    logic [31:0] e_rc;
    int          e_np;
  } vec_t;

  vec_t tbl [7];

  tpm_response_tx #(.MAX_PARAM(MAX_P)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .rsp_start  (rsp_start),
    .tpm_rc     (tpm_rc),
    .rsp_tag    (rsp_tag),
    .param_len  (param_len),
    .param_rd_en(param_rd_en),
    .param_addr (param_addr),
    .param_data (param_data),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_last    (tx_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  // External parameter buffer: synchronous read, data one cycle after the strobe.
  always @(posedge clock) begin
    if (param_rd_en) param_data <= mem[param_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: what header and how many parameter bytes a request yields.
  task automatic model(input logic [31:0] rc, input logic [15:0] tag, input logic [15:0] plen,
                       output vec_t v);
    v.rc = rc; v.tag = tag; v.plen = plen;
    if (rc != 0) begin
      v.e_tag = 16'h8001; v.e_size = 10; v.e_rc = rc; v.e_np = 0;
    end else if (int'(plen) > MAX_P) begin
      v.e_tag = 16'h8001; v.e_size = 10; v.e_rc = 32'h101; v.e_np = 0;
    end else begin
      v.e_tag = tag; v.e_size = 32'd10 + 32'(plen); v.e_rc = 0; v.e_np = int'(plen);
    end
  endtask

  task automatic run_case(input vec_t v, input string nm);
    logic [7:0] exp_q[$];
    logic [7:0] got[$];
    logic       lastf[$];
    logic [9:0] addrs[$];
    logic [7:0] hd;
    logic       hl;
    logic       rdy;
    bit         stalled;
    bit         finished;
    int         fin_cyc;
    int         budget;

    exp_q.push_back(v.e_tag[15:8]);  exp_q.push_back(v.e_tag[7:0]);
    exp_q.push_back(v.e_size[31:24]); exp_q.push_back(v.e_size[23:16]);
    exp_q.push_back(v.e_size[15:8]);  exp_q.push_back(v.e_size[7:0]);
    exp_q.push_back(v.e_rc[31:24]);   exp_q.push_back(v.e_rc[23:16]);
    exp_q.push_back(v.e_rc[15:8]);    exp_q.push_back(v.e_rc[7:0]);
    for (int i = 0; i < v.e_np; i++) exp_q.push_back(mem[i]);

    tpm_rc = v.rc; rsp_tag = v.tag; param_len = v.plen; rsp_start = 1'b1; tx_ready = 1'b0;
    @(negedge clock);
    rsp_start = 1'b0;
    // Inputs must have been latched; scramble them.
    tpm_rc = $urandom; rsp_tag = 16'($urandom); param_len = 16'($urandom);
    chk({nm, " first_valid"}, 32'(tx_valid), 1);
    chk({nm, " busy_start"}, 32'(busy), 1);

    stalled = 0; finished = 0; fin_cyc = -1; hd = 0; hl = 0;
    budget = 10 * exp_q.size() + 100;
    for (int cyc = 0; cyc < budget && !finished; cyc++) begin
      if (stalled) begin
        chk({nm, " stall_valid"}, 32'(tx_valid), 1);
        chk({nm, " stall_data"}, 32'(tx_data), 32'(hd));
        chk({nm, " stall_last"}, 32'(tx_last), 32'(hl));
      end
      if (done) chk({nm, " early_done"}, 32'(done), 0);
      if (!busy) chk({nm, " busy_mid"}, 32'(busy), 1);
      if (param_rd_en) addrs.push_back(param_addr);
      rsp_start = 1'($urandom_range(1, 0));
      if (tx_valid) begin
        rdy = (32'($urandom_range(99, 0)) >= 32'(v.stall));
        tx_ready = rdy;
        if (rdy) begin
          got.push_back(tx_data);
          lastf.push_back(tx_last);
          stalled = 0;
          if (tx_last) begin finished = 1; fin_cyc = cyc; end
        end else begin
          stalled = 1; hd = tx_data; hl = tx_last;
        end
      end else begin
        tx_ready = 1'($urandom_range(1, 0));
        stalled = 0;
      end
      @(negedge clock);
    end

    chk({nm, " finished"}, 32'(finished), 1);
    chk({nm, " done_pulse"}, 32'(done), 1);
    chk({nm, " byte_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s byte%0d", nm, i), 32'(got[i]), 32'(exp_q[i]));
      chk($sformatf("%s last%0d", nm, i), 32'(lastf[i]), 32'(i == exp_q.size() - 1));
    end
    chk({nm, " addr_count"}, 32'(addrs.size()), 32'(v.e_np));
    for (int i = 0; i < addrs.size(); i++)
      chk($sformatf("%s addr%0d", nm, i), 32'(addrs[i]), 32'(i));
    if (v.stall == 0) chk({nm, " cycles"}, 32'(fin_cyc), 32'(9 + 2 * v.e_np));

    // A start request during DONE must not launch a new response.
    rsp_start = 1'b1; tx_ready = 1'b1;
    @(negedge clock);
    rsp_start = 1'b0;
    chk({nm, " idle_busy"}, 32'(busy), 0);
    chk({nm, " idle_done"}, 32'(done), 0);
    chk({nm, " idle_valid"}, 32'(tx_valid), 0);
  endtask

  initial begin
    vec_t rv;
    int   cnt;
    logic [31:0] rrc;
    logic [15:0] rpl;

    //        rc            tag       plen   stall  e_tag     e_size  e_rc          e_np
    tbl[0] = '{32'h0,       16'h8001, 16'd0,    0, 16'h8001, 32'd10,   32'h0,       0};
    tbl[1] = '{32'h0,       16'h8002, 16'd3,    0, 16'h8002, 32'd13,   32'h0,       3};
    tbl[2] = '{32'h100,     16'h8002, 16'd5,    0, 16'h8001, 32'd10,   32'h100,     0};
    tbl[3] = '{32'h0,       16'h8002, 16'd1015, 0, 16'h8001, 32'd10,   32'h101,     0};
    tbl[4] = '{32'h0,       16'h8002, 16'd3,   50, 16'h8002, 32'd13,   32'h0,       3};
    tbl[5] = '{32'h0,       16'h8001, 16'd1014, 0, 16'h8001, 32'd1024, 32'h0,    1014};
    tbl[6] = '{32'h0,       16'h8002, 16'd1,   30, 16'h8002, 32'd11,   32'h0,       1};

    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom_range(255, 0));
    mem[0] = 8'hAA; mem[1] = 8'hBB; mem[2] = 8'hCC;

    reset_n = 1'b0; rsp_start = 1'b0; tx_ready = 1'b0;
    tpm_rc = 0; rsp_tag = 0; param_len = 0;
    repeat (2) @(negedge clock);
    chk("rst tx_valid", 32'(tx_valid), 0);
    chk("rst tx_last", 32'(tx_last), 0);
    chk("rst tx_data", 32'(tx_data), 0);
    chk("rst rd_en", 32'(param_rd_en), 0);
    chk("rst addr", 32'(param_addr), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    reset_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 7; i++) run_case(tbl[i], $sformatf("tbl%0d", i));

    for (int i = 0; i < 20; i++) begin
      rrc = ($urandom_range(9, 0) < 7) ? 32'h0 : $urandom;
      case ($urandom_range(9, 0))
        0:       rpl = 16'($urandom_range(2000, 1015));
        1:       rpl = 16'($urandom_range(1014, 1000));
        default: rpl = 16'($urandom_range(24, 0));
      endcase
      model(rrc, $urandom_range(1, 0) ? 16'h8002 : 16'h8001, rpl, rv);
      rv.stall = int'($urandom_range(60, 0));
      run_case(rv, $sformatf("rnd%0d", i));
    end

    // Reset in the middle of a header, after four bytes have gone out.
    tpm_rc = 0; rsp_tag = 16'h8002; param_len = 16'd3; rsp_start = 1'b1;
    @(negedge clock);
    rsp_start = 1'b0; tx_ready = 1'b1; cnt = 0;
    for (int c = 0; c < 20 && cnt < 4; c++) begin
      if (tx_valid) cnt++;
      @(negedge clock);
    end
    chk("mid bytes_sent", 32'(cnt), 4);
    reset_n = 1'b0;
    @(negedge clock);
    chk("mid rst valid", 32'(tx_valid), 0);
    chk("mid rst busy", 32'(busy), 0);
    chk("mid rst data", 32'(tx_data), 0);
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      chk("mid residual", 32'({tx_valid, done, busy}), 0);
    end
    run_case(tbl[0], "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
